// File: rtl/char_power_ctrl.sv
// char_power_ctrl: character power level (SMALL/BIG/FIRE) with grow/shrink
// animations, post-hit invulnerability blink and sticky death.
// Build option: define POWER_FIRE_EN to make the FIRE level reachable via
// touch_flower; without it a flower counts as a mushroom.
module char_power_ctrl #(
  parameter int ANIM_FRAMES   = 24,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_DIV     = 4
) (
  input  logic       sys_clk,
  input  logic       RST_N,
  input  logic       frame_tick,
  input  logic       touch_flower,
  input  logic       touch_mushroom,
  input  logic       hit_enemy,
  input  logic       fall_dead,
  output logic [1:0] power_state,
  output logic       char_big,
  output logic       anim_busy,
  output logic       invuln,
  output logic       visible,
  output logic       dead,
  output logic       pickup_ack
);

  localparam int AW = $clog2(ANIM_FRAMES + 1);
  localparam int IW = $clog2(INVULN_FRAMES + 1);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [2:0] {
    ST_SMALL, ST_BIG, ST_FIRE, ST_GROW, ST_SHRINK, ST_DEAD
  } state_t;

  typedef enum logic [1:0] {
    PEND_NONE, PEND_MUSH, PEND_FLOW
  } pend_t;

  state_t          state_q, state_d;
  logic            target_fire_q, target_fire_d;
  logic [AW-1:0]   anim_cnt_q, anim_cnt_d;
  logic [1:0]      anim_div_q, anim_div_d;
  logic [IW-1:0]   inv_cnt_q, inv_cnt_d;
  logic [BW-1:0]   blink_div_q, blink_div_d;
  pend_t           pend_q, pend_d;

  logic [1:0]      power_state_q, power_state_d;
  logic            char_big_q, char_big_d;
  logic            anim_busy_q, anim_busy_d;
  logic            invuln_q, invuln_d;
  logic            visible_q, visible_d;
  logic            dead_q, dead_d;
  logic            pickup_ack_q, pickup_ack_d;

  logic            pick_flow;
  logic            pick_any;
  pend_t           pick_in;
  pend_t           pick_now;
  state_t          settle;
  logic            apply_pick;
  logic            anim_load;
  logic            anim_toggle;
  logic            blink_toggle;
  logic            hit_ok;

`ifdef POWER_FIRE_EN
  assign pick_flow = touch_flower;
`else
  assign pick_flow = 1'b0;
`endif
  assign pick_any = touch_flower | touch_mushroom;
  assign hit_ok   = !invuln_q && !anim_busy_q && !dead_q;

  // Flower wins over mushroom when two pickups have to be folded together.
  function automatic pend_t merge_pick(input pend_t a, input pend_t b);
    if (a == PEND_FLOW || b == PEND_FLOW) return PEND_FLOW;
    if (a == PEND_MUSH || b == PEND_MUSH) return PEND_MUSH;
    return PEND_NONE;
  endfunction

  // Classify this cycle's pickup pulse, flower taking priority.
  always_comb begin
    pick_in = PEND_NONE;
    if (pick_flow) pick_in = PEND_FLOW;
    else if (pick_any) pick_in = PEND_MUSH;
  end

  // State register: all flops, async active-low reset.
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_SMALL;
      target_fire_q <= 1'b0;
      anim_cnt_q    <= '0;
      anim_div_q    <= '0;
      inv_cnt_q     <= '0;
      blink_div_q   <= '0;
      pend_q        <= PEND_NONE;
      power_state_q <= 2'd0;
      char_big_q    <= 1'b0;
      anim_busy_q   <= 1'b0;
      invuln_q      <= 1'b0;
      visible_q     <= 1'b1;
      dead_q        <= 1'b0;
      pickup_ack_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_fire_q <= target_fire_d;
      anim_cnt_q    <= anim_cnt_d;
      anim_div_q    <= anim_div_d;
      inv_cnt_q     <= inv_cnt_d;
      blink_div_q   <= blink_div_d;
      pend_q        <= pend_d;
      power_state_q <= power_state_d;
      char_big_q    <= char_big_d;
      anim_busy_q   <= anim_busy_d;
      invuln_q      <= invuln_d;
      visible_q     <= visible_d;
      dead_q        <= dead_d;
      pickup_ack_q  <= pickup_ack_d;
    end
  end

  // Next state: event priority, animation/invulnerability timers, pending pickup.
  always_comb begin
    state_d       = state_q;
    target_fire_d = target_fire_q;
    anim_cnt_d    = anim_cnt_q;
    anim_div_d    = anim_div_q;
    inv_cnt_d     = inv_cnt_q;
    blink_div_d   = blink_div_q;
    pend_d        = pend_q;
    anim_load     = 1'b0;
    anim_toggle   = 1'b0;
    blink_toggle  = 1'b0;
    settle        = state_q;
    pick_now      = PEND_NONE;
    apply_pick    = 1'b0;

    if (state_q != ST_DEAD) begin
      if (frame_tick && inv_cnt_q != '0) begin
        inv_cnt_d = inv_cnt_q - IW'(1);
        if (blink_div_q == BW'(BLINK_DIV - 1)) begin
          blink_div_d  = '0;
          blink_toggle = 1'b1;
        end else begin
          blink_div_d = blink_div_q + BW'(1);
        end
      end

      if (fall_dead || (hit_enemy && hit_ok && state_q == ST_SMALL)) begin
        state_d     = ST_DEAD;
        pend_d      = PEND_NONE;
        anim_cnt_d  = '0;
        anim_div_d  = '0;
        inv_cnt_d   = '0;
        blink_div_d = '0;
      end else if (hit_enemy && hit_ok) begin
        state_d    = ST_SHRINK;
        anim_cnt_d = AW'(ANIM_FRAMES);
        anim_div_d = '0;
        anim_load  = 1'b1;
        pend_d     = pick_in;
      end else if (state_q == ST_GROW || state_q == ST_SHRINK) begin
        pick_now = merge_pick(pend_q, pick_in);
        pend_d   = pick_now;
        if (frame_tick) begin
          if (anim_cnt_q <= AW'(1)) begin
            anim_cnt_d = '0;
            anim_div_d = '0;
            pend_d     = PEND_NONE;
            apply_pick = 1'b1;
            if (state_q == ST_GROW) begin
              settle = target_fire_q ? ST_FIRE : ST_BIG;
            end else begin
              settle      = ST_SMALL;
              inv_cnt_d   = IW'(INVULN_FRAMES);
              blink_div_d = '0;
            end
          end else begin
            anim_cnt_d = anim_cnt_q - AW'(1);
            if (anim_div_q == 2'd3) begin
              anim_div_d  = '0;
              anim_toggle = 1'b1;
            end else begin
              anim_div_d = anim_div_q + 2'd1;
            end
          end
        end
      end else begin
        pick_now   = pick_in;
        apply_pick = 1'b1;
      end

      if (apply_pick) begin
        state_d = settle;
        if (settle == ST_SMALL && pick_now != PEND_NONE) begin
          state_d       = ST_GROW;
          target_fire_d = 1'b0;
          anim_cnt_d    = AW'(ANIM_FRAMES);
          anim_div_d    = '0;
          anim_load     = 1'b1;
        end else if (settle == ST_BIG && pick_now == PEND_FLOW) begin
          state_d       = ST_GROW;
          target_fire_d = 1'b1;
          anim_cnt_d    = AW'(ANIM_FRAMES);
          anim_div_d    = '0;
          anim_load     = 1'b1;
        end
      end
    end
  end

  // Outputs: derive next registered output values from the next state.
  always_comb begin
    power_state_d = 2'd0;
    char_big_d    = 1'b0;
    case (state_d)
      ST_BIG: begin
        power_state_d = 2'd1;
        char_big_d    = 1'b1;
      end
      ST_FIRE: begin
        power_state_d = 2'd2;
        char_big_d    = 1'b1;
      end
      ST_GROW: begin
        power_state_d = target_fire_d ? 2'd1 : 2'd0;
        char_big_d    = anim_load ? 1'b1 : (anim_toggle ? ~char_big_q : char_big_q);
      end
      ST_SHRINK: begin
        power_state_d = power_state_q;
        char_big_d    = anim_load ? 1'b0 : (anim_toggle ? ~char_big_q : char_big_q);
      end
      default: begin
        power_state_d = 2'd0;
        char_big_d    = 1'b0;
      end
    endcase
    anim_busy_d  = (state_d == ST_GROW) || (state_d == ST_SHRINK);
    dead_d       = (state_d == ST_DEAD);
    invuln_d     = (state_d != ST_DEAD) && ((state_d == ST_SHRINK) || (inv_cnt_d != '0));
    if (state_d == ST_DEAD || inv_cnt_d == '0) visible_d = 1'b1;
    else visible_d = blink_toggle ? ~visible_q : visible_q;
    pickup_ack_d = (state_q != ST_DEAD) && pick_any;
  end

  assign power_state = power_state_q;
  assign char_big    = char_big_q;
  assign anim_busy   = anim_busy_q;
  assign invuln      = invuln_q;
  assign visible     = visible_q;
  assign dead        = dead_q;
  assign pickup_ack  = pickup_ack_q;

endmodule

// File: tb/tb_char_power_ctrl.sv
// tb_char_power_ctrl: directed self-checking bench for char_power_ctrl.
// Expectations follow POWER_FIRE_EN when the build defines it.
module tb_char_power_ctrl;

  logic       sys_clk = 1'b0;
  logic       RST_N = 1'b0;
  logic       frame_tick = 1'b0;
  logic       touch_flower = 1'b0;
  logic       touch_mushroom = 1'b0;
  logic       hit_enemy = 1'b0;
  logic       fall_dead = 1'b0;
  logic [1:0] power_state;
  logic       char_big;
  logic       anim_busy;
  logic       invuln;
  logic       visible;
  logic       dead;
  logic       pickup_ack;

  int total_cnt = 0;
  int bad_cnt = 0;

`ifdef POWER_FIRE_EN
  localparam logic [1:0] TOP_LEVEL = 2'd2;
`else
  localparam logic [1:0] TOP_LEVEL = 2'd1;
`endif

  char_power_ctrl dut (
    .sys_clk(sys_clk),
    .RST_N(RST_N),
    .frame_tick(frame_tick),
    .touch_flower(touch_flower),
    .touch_mushroom(touch_mushroom),
    .hit_enemy(hit_enemy),
    .fall_dead(fall_dead),
    .power_state(power_state),
    .char_big(char_big),
    .anim_busy(anim_busy),
    .invuln(invuln),
    .visible(visible),
    .dead(dead),
    .pickup_ack(pickup_ack)
  );

  // Free-running 10ns system clock.
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total_cnt++;
    if (obs !== expv) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0d want %0d", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic fl, input logic mu, input logic hit, input logic fall);
    touch_flower   = fl;
    touch_mushroom = mu;
    hit_enemy      = hit;
    fall_dead      = fall;
    step();
    touch_flower   = 1'b0;
    touch_mushroom = 1'b0;
    hit_enemy      = 1'b0;
    fall_dead      = 1'b0;
  endtask

  task automatic runFrames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic doReset();
    RST_N = 1'b0;
    step();
    step();
    RST_N = 1'b1;
    step();
  endtask

  initial begin
    $display("[TB] start");
    doReset();
    checkOutput("rst_power", power_state, 0);
    checkOutput("rst_big", char_big, 0);
    checkOutput("rst_busy", anim_busy, 0);
    checkOutput("rst_invuln", invuln, 0);
    checkOutput("rst_visible", visible, 1);
    checkOutput("rst_dead", dead, 0);
    checkOutput("rst_ack", pickup_ack, 0);

    // SMALL + mushroom -> grow to BIG over 24 frames
    applyStimulus(0, 1, 0, 0);
    checkOutput("grow_ack", pickup_ack, 1);
    checkOutput("grow_busy", anim_busy, 1);
    checkOutput("grow_big_start", char_big, 1);
    checkOutput("grow_power_hold", power_state, 0);
    step();
    checkOutput("grow_ack_once", pickup_ack, 0);
    runFrames(4);
    checkOutput("grow_big_t4", char_big, 0);
    runFrames(19);
    checkOutput("grow_busy_t23", anim_busy, 1);
    checkOutput("grow_big_t23", char_big, 0);
    runFrames(1);
    checkOutput("grow_end_power", power_state, 1);
    checkOutput("grow_end_big", char_big, 1);
    checkOutput("grow_end_busy", anim_busy, 0);

    // BIG + mushroom: ack only
    applyStimulus(0, 1, 0, 0);
    checkOutput("bigmush_ack", pickup_ack, 1);
    checkOutput("bigmush_busy", anim_busy, 0);
    checkOutput("bigmush_power", power_state, 1);

    // BIG + flower
    applyStimulus(1, 0, 0, 0);
    checkOutput("bigflow_ack", pickup_ack, 1);
`ifdef POWER_FIRE_EN
    checkOutput("bigflow_busy", anim_busy, 1);
    checkOutput("bigflow_power_hold", power_state, 1);
    runFrames(24);
    checkOutput("fire_power", power_state, 2);
    checkOutput("fire_busy", anim_busy, 0);
`else
    checkOutput("bigflow_busy", anim_busy, 0);
    step();
    checkOutput("bigflow_power", power_state, 1);
`endif

    // Hit from top level -> shrink, invulnerability, blink
    applyStimulus(0, 0, 1, 0);
    checkOutput("shrink_busy", anim_busy, 1);
    checkOutput("shrink_invuln", invuln, 1);
    checkOutput("shrink_big_start", char_big, 0);
    checkOutput("shrink_power_hold", power_state, TOP_LEVEL);
    runFrames(24);
    checkOutput("shrink_end_power", power_state, 0);
    checkOutput("shrink_end_busy", anim_busy, 0);
    checkOutput("shrink_end_invuln", invuln, 1);
    checkOutput("shrink_end_visible", visible, 1);
    runFrames(4);
    checkOutput("blink_f28", visible, 0);
    runFrames(4);
    checkOutput("blink_f32", visible, 1);
    runFrames(18);
    applyStimulus(0, 0, 1, 0);
    checkOutput("hit_f50_dead", dead, 0);
    checkOutput("hit_f50_busy", anim_busy, 0);
    checkOutput("hit_f50_power", power_state, 0);
    runFrames(93);
    checkOutput("inv_t119", invuln, 1);
    checkOutput("vis_t119", visible, 0);
    runFrames(1);
    checkOutput("inv_t120", invuln, 0);
    checkOutput("vis_t120", visible, 1);

    // Pickup pending during GROW
    applyStimulus(0, 1, 0, 0);
    runFrames(10);
    applyStimulus(1, 0, 0, 0);
    checkOutput("pend_ack", pickup_ack, 1);
    checkOutput("pend_busy", anim_busy, 1);
    runFrames(14);
    checkOutput("pend_end_power", power_state, 1);
    checkOutput("pend_end_big", char_big, 1);
`ifdef POWER_FIRE_EN
    checkOutput("pend_regrow_busy", anim_busy, 1);
    runFrames(24);
    checkOutput("pend_fire_power", power_state, 2);
`else
    checkOutput("pend_regrow_busy", anim_busy, 0);
`endif

    // Reset mid-GROW: asynchronous return to reset values, nothing carried
    doReset();
    applyStimulus(0, 1, 0, 0);
    runFrames(5);
    applyStimulus(0, 1, 0, 0);
    #2 RST_N = 1'b0;
    #1;
    checkOutput("midrst_busy", anim_busy, 0);
    checkOutput("midrst_big", char_big, 0);
    checkOutput("midrst_ack", pickup_ack, 0);
    step();
    RST_N = 1'b1;
    runFrames(30);
    checkOutput("midrst_after_busy", anim_busy, 0);
    checkOutput("midrst_after_power", power_state, 0);

    // SMALL: hit + mushroom same cycle -> dead, still acked
    applyStimulus(0, 1, 1, 0);
    checkOutput("die_dead", dead, 1);
    checkOutput("die_ack", pickup_ack, 1);
    checkOutput("die_busy", anim_busy, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("dead_mush_ack", pickup_ack, 0);
    checkOutput("dead_mush_busy", anim_busy, 0);
    runFrames(3);
    checkOutput("dead_sticky", dead, 1);

    // fall_dead mid-shrink overrides everything
    doReset();
    checkOutput("rst2_dead", dead, 0);
    applyStimulus(0, 1, 0, 0);
    runFrames(24);
    applyStimulus(0, 0, 1, 0);
    runFrames(3);
    applyStimulus(0, 0, 0, 1);
    checkOutput("fall_dead", dead, 1);
    checkOutput("fall_busy", anim_busy, 0);
    checkOutput("fall_invuln", invuln, 0);
    checkOutput("fall_visible", visible, 1);
    checkOutput("fall_big", char_big, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
